// File: rtl/rgb2ycbcr_cfg.sv
// rgb2ycbcr_cfg: frame-synchronous RGB to YCbCr colour-space converter.
//
// Purpose
//   Expands R/G/B to 8 bits by MSB replication, then converts with a
//   4-stage pipeline:
//   1. expand + multiply
//   2. sum
//   3. shift / round / clamp
//   4. output gate
//   The conversion mode is latched only on a vsync rising edge. Each pixel
//   carries its mode through the pipeline, so a mode change never corrupts
//   pixels that are already in flight.
//
// Modes (cfg_mode / mode_active)
//   00  BT.601
//   01  BT.709
//   10  grayscale (BT.601 Y, Cb = Cr = 128)
//   11  RGB888 passthrough (Y = R8, Cb = G8, Cr = B8)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_mode[1:0]                   requested mode, sampled on vsync rise
//   pre_frame_vsync/hsync/de        input syncs
//   img_red/green/blue              input pixel (R_W/G_W/B_W bits)
//   post_frame_vsync/hsync/de       syncs delayed 4 clk
//   img_y/cb/cr[7:0]                converted pixel, 0 when post_frame_de=0
//   mode_active[1:0]                mode currently applied at pipeline input
//
// Build option
//   CSC_ROUND_EN  defined: add 128 before >>8 (round-half-up) in modes 00/01/10.
//                 undefined: truncate.
module rgb2ycbcr_cfg #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     cfg_mode,
  input  logic           pre_frame_vsync,
  input  logic           pre_frame_hsync,
  input  logic           pre_frame_de,
  input  logic [R_W-1:0] img_red,
  input  logic [G_W-1:0] img_green,
  input  logic [B_W-1:0] img_blue,
  output logic           post_frame_vsync,
  output logic           post_frame_hsync,
  output logic           post_frame_de,
  output logic [7:0]     img_y,
  output logic [7:0]     img_cb,
  output logic [7:0]     img_cr,
  output logic [1:0]     mode_active
);

  localparam logic signed [17:0] OFFSET = 18'sd32768;
`ifdef CSC_ROUND_EN
  localparam logic signed [17:0] RND_BIAS = 18'sd128;
`else
  localparam logic signed [17:0] RND_BIAS = 18'sd0;
`endif

  // channel expansion
  logic [7:0] r8, g8, b8;

  if (R_W == 8) begin : g_r_id
    assign r8 = img_red;
  end else begin : g_r_rep
    assign r8 = {img_red, img_red[R_W-1 -: 8-R_W]};
  end

  if (G_W == 8) begin : g_g_id
    assign g8 = img_green;
  end else begin : g_g_rep
    assign g8 = {img_green, img_green[G_W-1 -: 8-G_W]};
  end

  if (B_W == 8) begin : g_b_id
    assign b8 = img_blue;
  end else begin : g_b_rep
    assign b8 = {img_blue, img_blue[B_W-1 -: 8-B_W]};
  end

  // mode register, loaded on vsync rising edge only
  logic       vsync_q;
  logic [1:0] mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      vsync_q <= pre_frame_vsync;
      if (pre_frame_vsync && !vsync_q)
        mode_q <= cfg_mode;
    end
  end

  assign mode_active = mode_q;

  // Coefficients follow the mode register as it stands before any load in
  // this cycle, so the pixel entering on the edge cycle keeps the old mode.
  logic signed [17:0] k_yr, k_yg, k_yb, k_cbr, k_cbg, k_cbb, k_crr, k_crg, k_crb;

  always_comb begin
    k_yr  = 18'sd77;   k_yg  = 18'sd150;  k_yb  = 18'sd29;
    k_cbr = -18'sd43;  k_cbg = -18'sd85;  k_cbb = 18'sd128;
    k_crr = 18'sd128;  k_crg = -18'sd107; k_crb = -18'sd21;
    if (mode_q == 2'b01) begin
      k_yr  = 18'sd54;   k_yg  = 18'sd183;  k_yb  = 18'sd19;
      k_cbr = -18'sd29;  k_cbg = -18'sd99;  k_cbb = 18'sd128;
      k_crr = 18'sd128;  k_crg = -18'sd116; k_crb = -18'sd12;
    end
  end

  logic signed [17:0] pix_r, pix_g, pix_b;
  assign pix_r = $signed({10'd0, r8});
  assign pix_g = $signed({10'd0, g8});
  assign pix_b = $signed({10'd0, b8});

  // stage 1: expand + multiply
  logic signed [17:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
  logic [7:0]         r1, g1, b1;
  logic [1:0]         m1;
  logic               v1, h1, de1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_yr <= '0;  p_yg <= '0;  p_yb <= '0;
      p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
      p_crr <= '0; p_crg <= '0; p_crb <= '0;
      r1 <= '0; g1 <= '0; b1 <= '0; m1 <= '0;
      v1 <= 1'b0; h1 <= 1'b0; de1 <= 1'b0;
    end else begin
      p_yr  <= pix_r * k_yr;  p_yg  <= pix_g * k_yg;  p_yb  <= pix_b * k_yb;
      p_cbr <= pix_r * k_cbr; p_cbg <= pix_g * k_cbg; p_cbb <= pix_b * k_cbb;
      p_crr <= pix_r * k_crr; p_crg <= pix_g * k_crg; p_crb <= pix_b * k_crb;
      r1 <= r8; g1 <= g8; b1 <= b8; m1 <= mode_q;
      v1 <= pre_frame_vsync; h1 <= pre_frame_hsync; de1 <= pre_frame_de;
    end
  end

  // stage 2: sum, with chroma offset and optional rounding bias
  logic signed [17:0] s_y, s_cb, s_cr;
  logic [7:0]         r2, g2, b2;
  logic [1:0]         m2;
  logic               v2, h2, de2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_y <= '0; s_cb <= '0; s_cr <= '0;
      r2 <= '0; g2 <= '0; b2 <= '0; m2 <= '0;
      v2 <= 1'b0; h2 <= 1'b0; de2 <= 1'b0;
    end else begin
      s_y  <= p_yr + p_yg + p_yb + RND_BIAS;
      s_cb <= p_cbr + p_cbg + p_cbb + OFFSET + RND_BIAS;
      s_cr <= p_crr + p_crg + p_crb + OFFSET + RND_BIAS;
      r2 <= r1; g2 <= g1; b2 <= b1; m2 <= m1;
      v2 <= v1; h2 <= h1; de2 <= de1;
    end
  end

  // stage 3: shift, clamp, mode select
  function automatic logic [7:0] clamp8(input logic signed [17:0] s);
    logic signed [17:0] q;
    q = s >>> 8;
    if (q < 18'sd0)        clamp8 = 8'd0;
    else if (q > 18'sd255) clamp8 = 8'hFF;
    else                   clamp8 = q[7:0];
  endfunction

  logic [7:0] y_n, cb_n, cr_n;

  always_comb begin
    y_n  = clamp8(s_y);
    cb_n = clamp8(s_cb);
    cr_n = clamp8(s_cr);
    case (m2)
      2'b10: begin
        cb_n = 8'd128;
        cr_n = 8'd128;
      end
      2'b11: begin
        y_n  = r2;
        cb_n = g2;
        cr_n = b2;
      end
      default: ;
    endcase
  end

  logic [7:0] y3, cb3, cr3;
  logic       v3, h3, de3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y3 <= '0; cb3 <= '0; cr3 <= '0;
      v3 <= 1'b0; h3 <= 1'b0; de3 <= 1'b0;
    end else begin
      y3 <= y_n; cb3 <= cb_n; cr3 <= cr_n;
      v3 <= v2; h3 <= h2; de3 <= de2;
    end
  end

  // stage 4: output gate, pixel forced to 0 outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_y <= '0; img_cb <= '0; img_cr <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
    end else begin
      img_y  <= de3 ? y3  : 8'd0;
      img_cb <= de3 ? cb3 : 8'd0;
      img_cr <= de3 ? cr3 : 8'd0;
      post_frame_vsync <= v3;
      post_frame_hsync <= h3;
      post_frame_de    <= de3;
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_cfg.sv
// Testbench for rgb2ycbcr_cfg (default 5/6/5 widths). Expected values are
// hand-computed; the CSC_ROUND_EN column is used when that macro is defined.
module tb_rgb2ycbcr_cfg;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     cfg_mode;
  logic           pre_frame_vsync, pre_frame_hsync, pre_frame_de;
  logic [R_W-1:0] img_red;
  logic [G_W-1:0] img_green;
  logic [B_W-1:0] img_blue;
  logic           post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [7:0]     img_y, img_cb, img_cr;
  logic [1:0]     mode_active;

  rgb2ycbcr_cfg #(.R_W(R_W), .G_W(G_W), .B_W(B_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
    .pre_frame_de(pre_frame_de),
    .img_red(img_red), .img_green(img_green), .img_blue(img_blue),
    .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
    .post_frame_de(post_frame_de),
    .img_y(img_y), .img_cb(img_cb), .img_cr(img_cr),
    .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] r, g, b;
    int y_t, cb_t, cr_t;
    int y_r, cb_r, cr_r;
  } vec_t;

  vec_t vecs[13];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int t, input int r);
`ifdef CSC_ROUND_EN
    return r;
`else
    return t;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pre_frame_vsync = v;
    pre_frame_hsync = h;
    pre_frame_de    = de;
    img_red   = r[R_W-1:0];
    img_green = g[G_W-1:0];
    img_blue  = b[B_W-1:0];
  endtask

  task automatic set_mode(input logic [1:0] m);
    cfg_mode = m;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
    chk("mode_load", int'(mode_active), int'(m));
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat_de, pat_h, pat_v;
    int j, ev, eh, ed;

    vecs[0]  = '{2'b00, 8'd31, 8'd63, 8'd31, 255, 128, 128, 255, 128, 128};
    vecs[1]  = '{2'b00, 8'd31, 8'd0,  8'd0,   76,  85, 255,  77,  85, 255};
    vecs[2]  = '{2'b00, 8'd0,  8'd0,  8'd31,  28, 255, 107,  29, 255, 107};
    vecs[3]  = '{2'b00, 8'd0,  8'd63, 8'd0,  149,  43,  21, 149,  43,  21};
    vecs[4]  = '{2'b00, 8'd0,  8'd0,  8'd0,    0, 128, 128,   0, 128, 128};
    vecs[5]  = '{2'b00, 8'd16, 8'd32, 8'd16, 130, 128, 128, 131, 129, 129};
    vecs[6]  = '{2'b01, 8'd31, 8'd63, 8'd31, 255, 128, 128, 255, 128, 128};
    vecs[7]  = '{2'b01, 8'd31, 8'd0,  8'd0,   53,  99, 255,  54,  99, 255};
    vecs[8]  = '{2'b01, 8'd0,  8'd0,  8'd31,  18, 255, 116,  19, 255, 116};
    vecs[9]  = '{2'b10, 8'd31, 8'd0,  8'd0,   76, 128, 128,  77, 128, 128};
    vecs[10] = '{2'b10, 8'd16, 8'd32, 8'd16, 130, 128, 128, 131, 128, 128};
    vecs[11] = '{2'b11, 8'd31, 8'd0,  8'd16, 255,   0, 132, 255,   0, 132};
    vecs[12] = '{2'b11, 8'd16, 8'd32, 8'd0,  132, 130,   0, 132, 130,   0};

    // reset state
    rst_n = 1'b0;
    cfg_mode = 2'b00;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    chk("rst_post_de", int'(post_frame_de), 0);
    chk("rst_post_vs", int'(post_frame_vsync), 0);
    chk("rst_img_y", int'(img_y), 0);
    chk("rst_img_cb", int'(img_cb), 0);
    chk("rst_mode", int'(mode_active), 0);
    rst_n = 1'b1;
    step();

    // table-driven single pixels, 4-clk latency each
    for (int i = 0; i < 13; i++) begin
      if (mode_active != vecs[i].mode) set_mode(vecs[i].mode);
      drive(1'b0, 1'b1, 1'b1, vecs[i].r, vecs[i].g, vecs[i].b);
      step();
      drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      step();
      step();
      chk("lat_de_early", int'(post_frame_de), 0);
      step();
      chk("lat_de", int'(post_frame_de), 1);
      chk("lat_hs", int'(post_frame_hsync), 1);
      chk($sformatf("vec%0d_y", i), int'(img_y), pick(vecs[i].y_t, vecs[i].y_r));
      chk($sformatf("vec%0d_cb", i), int'(img_cb), pick(vecs[i].cb_t, vecs[i].cb_r));
      chk($sformatf("vec%0d_cr", i), int'(img_cr), pick(vecs[i].cr_t, vecs[i].cr_r));
      step();
      chk("gate_after_de", int'(img_cr) + int'(img_cb) + int'(img_y), 0);
    end

    // mode change mid-frame ignored, load on vsync rise, in-flight pixels keep mode
    set_mode(2'b00);
    cfg_mode = 2'b11;
    step();
    step();
    chk("midframe_ignore", int'(mode_active), 0);
    drive(1'b0, 1'b0, 1'b1, 8'd31, 8'd0, 8'd0);           // P0, mode 00
    step();
    cfg_mode = 2'b01;
    drive(1'b1, 1'b0, 1'b1, 8'd31, 8'd0, 8'd0);           // P1, edge cycle, mode 00
    step();
    chk("edge_capture", int'(mode_active), 1);
    cfg_mode = 2'b10;
    drive(1'b1, 1'b0, 1'b1, 8'd31, 8'd0, 8'd0);           // P2, vsync held, mode 01
    step();
    chk("vs_held_single", int'(mode_active), 1);
    drive(1'b0, 1'b0, 1'b1, 8'd31, 8'd63, 8'd31);         // P3 white, mode 01
    step();
    chk("p0_y_601", int'(img_y), pick(76, 77));
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
    chk("p1_y_601", int'(img_y), pick(76, 77));
    chk("p1_cb_601", int'(img_cb), 85);
    step();
    chk("p2_y_709", int'(img_y), pick(53, 54));
    chk("p2_cb_709", int'(img_cb), 99);
    step();
    chk("p3_y_709", int'(img_y), 255);
    chk("p3_cb_709", int'(img_cb), 128);
    chk("mode_kept", int'(mode_active), 1);
    step();
    step();

    // sync delay and output gating with toggling de
    cfg_mode = 2'b01;
    pat_de = 12'b000101001101;
    pat_h  = 12'b010011100111;
    pat_v  = 12'b001000000000;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) drive(pat_v[i], pat_h[i], pat_de[i], 8'd31, 8'd63, 8'd31);
      else        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      step();
      j = i - 3;
      ev = 0; eh = 0; ed = 0;
      if (j >= 0 && j < 12) begin
        ev = int'(pat_v[j]);
        eh = int'(pat_h[j]);
        ed = int'(pat_de[j]);
      end
      chk($sformatf("dly_vs_%0d", i), int'(post_frame_vsync), ev);
      chk($sformatf("dly_hs_%0d", i), int'(post_frame_hsync), eh);
      chk($sformatf("dly_de_%0d", i), int'(post_frame_de), ed);
      chk($sformatf("gate_y_%0d", i), int'(img_y), ed * 255);
      chk($sformatf("gate_cb_%0d", i), int'(img_cb), ed * 128);
      chk($sformatf("gate_cr_%0d", i), int'(img_cr), ed * 128);
    end

    // reset mid-frame with grayscale active
    set_mode(2'b10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 8'd31, 8'd0, 8'd0);
      step();
    end
    chk("pre_rst_y", int'(img_y), pick(76, 77));
    chk("pre_rst_cb", int'(img_cb), 128);
    chk("pre_rst_mode", int'(mode_active), 2);
    #3;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #1;
    chk("arst_de", int'(post_frame_de), 0);
    chk("arst_hs", int'(post_frame_hsync), 0);
    chk("arst_y", int'(img_y), 0);
    chk("arst_cb", int'(img_cb), 0);
    chk("arst_cr", int'(img_cr), 0);
    chk("arst_mode", int'(mode_active), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("no_stale_de_%0d", i), int'(post_frame_de), 0);
      chk($sformatf("no_stale_y_%0d", i), int'(img_y), 0);
    end
    drive(1'b0, 1'b0, 1'b1, 8'd31, 8'd0, 8'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    chk("post_rst_lat_early", int'(post_frame_de), 0);
    step();
    chk("post_rst_de", int'(post_frame_de), 1);
    chk("post_rst_y", int'(img_y), pick(76, 77));
    chk("post_rst_cb", int'(img_cb), 85);
    chk("post_rst_cr", int'(img_cr), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb2ycbcr_cfg.md
RGB2YCBCR_CFG -- requirements
Module: rgb2ycbcr_cfg

Interface
REQ-001 SHALL have parameter R_W, default 5, red input width (legal 4..8).
REQ-002 SHALL have parameter G_W, default 6, green input width (legal 4..8).
REQ-003 SHALL have parameter B_W, default 5, blue input width (legal 4..8).
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  requested conversion mode
- pre_frame_vsync  in  1  input vsync
- pre_frame_hsync  in  1  input hsync
- pre_frame_de  in  1  input data enable
- img_red  in  R_W  red
- img_green  in  G_W  green
- img_blue  in  B_W  blue
- post_frame_vsync  out  1  delayed vsync
- post_frame_hsync  out  1  delayed hsync
- post_frame_de  out  1  delayed data enable
- img_y  out  8  Y / channel 0
- img_cb  out  8  Cb / channel 1
- img_cr  out  8  Cr / channel 2
- mode_active  out  2  mode currently applied at pipeline input

Function
REQ-005 SHALL expand each channel to 8 bits by MSB replication: {x, x[W-1 -: 8-W]}; identity when W=8.
REQ-006 SHALL support modes: 00 BT.601, 01 BT.709, 10 grayscale, 11 RGB888 passthrough.
REQ-007 BT.601 SHALL use Y=(77R+150G+29B)>>8, Cb=(-43R-85G+128B+32768)>>8, Cr=(128R-107G-21B+32768)>>8.
REQ-008 BT.709 SHALL use Y=(54R+183G+19B)>>8, Cb=(-29R-99G+128B+32768)>>8, Cr=(128R-116G-12B+32768)>>8.
REQ-009 Grayscale SHALL output BT.601 Y with Cb=Cr=128; passthrough SHALL output Y=R8, Cb=G8, Cr=B8.
REQ-010 Sums SHALL be computed signed at least 18 bits wide, no intermediate overflow; result after shift SHALL clamp to 0..255.
REQ-011 Pipeline SHALL be 4 registered stages (expand+multiply, sum, shift/round/clamp, output gate); latency exactly 4 clk from input to img_*.
REQ-012 post_frame_vsync/hsync/de SHALL be the inputs delayed exactly 4 clk.
REQ-013 img_y/cb/cr SHALL be 0 whenever post_frame_de is 0.
REQ-014 Mode SHALL change only at frame boundary: active mode loads cfg_mode in the cycle pre_frame_vsync=1 while its prior-cycle sample was 0.
REQ-015 New mode SHALL apply to pixels entering on the cycle after the load; mode SHALL travel with each pixel through the pipeline, so in-flight pixels finish in their entry mode.
REQ-016 mode_active SHALL show the active mode register; cfg_mode changes outside a vsync rising edge SHALL be ignored.
REQ-017 vsync held high SHALL cause a single load only; a cfg_mode change on the edge cycle itself SHALL be captured.

Reset
REQ-018 rst_n low SHALL asynchronously clear all pipeline registers, sync delays, vsync edge sampler and outputs to 0, and mode_active to 00.
REQ-019 Reset mid-frame SHALL discard in-flight pixels; first valid output is 4 clk after the first pre_frame_de=1 following release.

Configuration
REQ-020 Macro CSC_ROUND_EN defined SHALL add 128 before >>8 in modes 00/01/10 (round-half-up); undefined SHALL truncate; clamp applies in both.

Verification
REQ-021 Mode 00, 565 white (31,63,31), de=1 -> 4 clk later Y=255, Cb=128, Cr=128.
REQ-022 Mode 00, red (31,0,0) -> Y=76, Cb=85, Cr=255 truncated; with CSC_ROUND_EN Y=77, Cb=85, Cr=255 (256 clamped).
REQ-023 Mode 00, blue (0,0,31) -> Cb=255, Cr=107; mode 11, (31,0,16) -> Y=255, Cb=0, Cr=132.
REQ-024 Switch cfg_mode 00->01 mid-frame -> mode_active stays 00 and outputs unchanged until next vsync rise; first pixel after it converts with BT.709 (white -> 255/128/128, red -> Y=53 truncated).
REQ-025 de toggling 1,0,1 with hsync high -> img_* zero exactly where post_frame_de=0; all post_* match inputs delayed 4 clk.
REQ-026 Assert rst_n low for one cycle mid-frame with mode 10 active -> all outputs 0 and mode_active=00 immediately; no stale pixel appears after release.
